pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the simplified MIPS core. It holds the architectural PC, drives the instruction-memory fetch handshake, and selects the next PC from the sequential/branch sums produced by the core's 32-bit adders, a jump target, or a register target. It sits directly upstream of the PC+4 adder, which consumes `pc`, and directly downstream of it, consuming `pc_plus4`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pc_plus4` in 32: `pc + 4` from the sequential adder.
- `branch_target` in 32: branch adder result.
- `branch_taken` in 1: conditional branch resolved taken.
- `jump` in 1: J/JAL.
- `jump_index` in 26: instruction index field.
- `jr` in 1: JR/JALR.
- `jr_addr` in 32: register-sourced target.
- `stall` in 1: hold the current instruction in EXEC.
- `halt` in 1: stop fetching after the current instruction.
- `imem_ready` in 1: instruction memory has data for `pc`.
- `pc` out 32: current PC, registered.
- `imem_req` out 1: fetch request for `pc`.
- `instr_valid` out 1: instruction at `pc` is being executed this cycle.
- `halted` out 1: sequencer stopped.
- `misalign_err` out 1: sticky flag; the selected next PC had bits [1:0] ≠ 0.
- `retired` out 32: count of completed instructions, wraps.

## Operation
- The FSM has three states: FETCH, EXEC and HALTED. Outputs are Moore-decoded from the state:
  - `imem_req` = (FETCH).
  - `instr_valid` = (EXEC).
  - `halted` = (HALTED).
- **Reset** (`rst_n` = 0 at an edge) overrides everything:
  - state = FETCH, `pc` = RESET_PC, `retired` = 0, `misalign_err` = 0.
  - Resulting outputs: `imem_req` = 1, `instr_valid` = 0, `halted` = 0.
  - Reset during any state, including HALTED, restarts cleanly.
- **FETCH**:
  - If `imem_ready` → EXEC; else stay in FETCH.
  - `pc` is held.
- **EXEC** (priority in this order):
  1. `stall` → stay in EXEC, `pc` held.
  2. else `halt` → HALTED, `pc` held, `retired` += 1.
  3. else compute `next_pc`:
     - if `next_pc[1:0]` ≠ 0 → HALTED, `misalign_err` = 1, `pc` held, `retired` += 1;
     - otherwise `pc` = `next_pc`, `retired` += 1, → FETCH.
- **HALTED**: absorbing state; all inputs are ignored until reset.
- **Next-PC selection** (priority high to low):
  - `jr` → `jr_addr`.
  - `jump` → {`pc_plus4[31:28]`, `jump_index`, 2'b00}.
  - `branch_taken` → `branch_target`.
  - else → `pc_plus4`.
- **Arithmetic**:
  - All addresses are 32-bit modulo 2^32. A `pc_plus4` wrap from 32'hFFFF_FFFC to 0 is accepted as-is.
  - `retired` wraps from 32'hFFFF_FFFF to 0.
- **Ignored inputs**:
  - `imem_ready` outside FETCH.
  - The control inputs (`jr`, `jump`, `branch_taken`, `stall`, `halt`) outside EXEC.

## Timing
- Reset values:
  - `pc` = RESET_PC
  - `imem_req` = 1
  - `instr_valid` = 0
  - `halted` = 0
  - `misalign_err` = 0
  - `retired` = 0
- Minimum 2 cycles per instruction: FETCH (with `imem_ready` = 1) then EXEC. Each extra FETCH cycle without `imem_ready` adds one cycle; each `stall` cycle in EXEC adds one cycle.
- `pc` changes only on the EXEC→FETCH edge. The new value is visible in the cycle `imem_req` reasserts.
- `retired` increments on the edge that leaves EXEC (to FETCH or HALTED), and on no other edge.
- Simultaneous events:
  - `stall` + `halt`: stall wins.
  - `halt` + `jr`/`jump`/`branch_taken`: halt wins and no PC update occurs.
  - Misalignment is checked only on the selected target.
- Next-PC logic is purely combinational from inputs sampled in EXEC. There is no internal adder; PC+4 is supplied externally.

## Structure
- Shared package `mips_pkg` holds:
  - the state encoding (FETCH = 2'd0, EXEC = 2'd1, HALTED = 2'd2);
  - next-PC select codes (SEL_SEQ, SEL_BR, SEL_J, SEL_JR);
  - the default RESET_PC.
- One sub-module: `next_pc_mux`, a combinational priority selector plus jump-address concatenation plus alignment check. Its outputs are `next_pc` and `next_misaligned`.
- The sequential FSM, PC register and `retired` counter live in `pc_sequencer`.

## Test plan
- **Reset then single sequential fetch.**
  - Stimulus: RESET_PC = 0; hold `rst_n` = 0 for 2 cycles, then release; `imem_ready` = 1; `pc_plus4` = 4.
  - Response: `pc` = 0 with `imem_req` = 1; next cycle `instr_valid` = 1; then `pc` = 4, `retired` = 1.
- **Memory wait states and stall.**
  - Stimulus: `imem_ready` low for 3 cycles, then high; then `stall` high for 2 EXEC cycles.
  - Response: `pc` stays constant for 7 cycles total; `instr_valid` is high for exactly 3 cycles; `retired` increments once.
- **Priority.**
  - Stimulus: in EXEC with `pc` = 32'h0040_0010, assert `jr` (`jr_addr` = 32'h0040_0100), `jump` (`jump_index` = 26'h000_0020) and `branch_taken` together.
  - Response: `pc` = 32'h0040_0100.
  - Stimulus: the same case with `jump` only.
  - Response: `pc` = 32'h0000_0080, with the upper nibble taken from `pc_plus4`.
- **Misaligned target.**
  - Stimulus: `branch_taken` with `branch_target` = 32'h0000_0102.
  - Response: HALTED, `misalign_err` = 1, `pc` unchanged, `retired` += 1; `imem_ready` pulses afterward are ignored.
- **Halt with simultaneous branch, then reset.**
  - Stimulus: `halt` + `branch_taken` in EXEC.
  - Response: `halted` = 1, `pc` unchanged.
  - Stimulus: then pulse `rst_n` low for 1 cycle.
  - Response: `pc` = RESET_PC, `halted` = 0, `retired` = 0, `misalign_err` = 0.
- **Wrap-around.**
  - Stimulus: preload the state via a `jr` to 32'hFFFF_FFFC, then sequential step with `pc_plus4` = 0.
  - Response: `pc` = 0, no error.
  - Stimulus: force `retired` near its maximum (hierarchical deposit of 32'hFFFF_FFFF), then retire one instruction.
  - Response: `retired` = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the simplified MIPS core front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: sequencer state encoding, next-PC select codes, default reset PC.
package mips_pkg;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      EXEC   = 2'd1,
      HALTED = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SEL_SEQ = 2'd0,
      SEL_BR  = 2'd1,
      SEL_J   = 2'd2,
      SEL_JR  = 2'd3
   } pc_sel_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC priority selector: jr > jump > taken branch > sequential, plus alignment check.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
// Ports: pc_plus4/branch_target/jr_addr/jump_index candidate sources, jr/jump/branch_taken
//        selects; next_pc is the chosen address, next_misaligned flags next_pc[1:0] != 0.
module next_pc_mux
   import mips_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] branch_target,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   output logic [31:0] next_pc,
   output logic        next_misaligned
);

   pc_sel_t sel;

   always_comb begin
      sel = SEL_SEQ;
      if (jr)
         sel = SEL_JR;
      else if (jump)
         sel = SEL_J;
      else if (branch_taken)
         sel = SEL_BR;
   end

   always_comb begin
      next_pc = pc_plus4;
      case (sel)
         SEL_JR:  next_pc = jr_addr;
         // J-type target keeps the 256 MB region of the delay-slot address (pc+4).
         SEL_J:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
         SEL_BR:  next_pc = branch_target;
         default: next_pc = pc_plus4;
      endcase
   end

   // Only the selected target is checked; unselected sources may be anything.
   assign next_misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, runs the FETCH/EXEC/HALTED loop, counts retirements.
// Latency: two cycles minimum per instruction (FETCH with imem_ready, then EXEC).
// Backpressure: imem_ready low holds FETCH; stall holds EXEC; both keep pc unchanged.
// Ports: clk/rst_n (sync, active-low); pc_plus4, branch/jump/jr sources and selects; stall, halt,
//        imem_ready in; pc, imem_req, instr_valid, halted, misalign_err (sticky), retired out.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_plus4,
   input  logic [31:0] branch_target,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   input  logic        stall,
   input  logic        halt,
   input  logic        imem_ready,
   output logic [31:0] pc,
   output logic        imem_req,
   output logic        instr_valid,
   output logic        halted,
   output logic        misalign_err,
   output logic [31:0] retired
);

   state_t      state, state_n;
   logic [31:0] next_pc;
   logic        next_misaligned;
   logic        pc_load;
   logic        retire;
   logic        set_err;
   logic [31:0] retired_cnt;

   next_pc_mux u_next_pc_mux (
      .pc_plus4        (pc_plus4),
      .branch_target   (branch_target),
      .branch_taken    (branch_taken),
      .jump            (jump),
      .jump_index      (jump_index),
      .jr              (jr),
      .jr_addr         (jr_addr),
      .next_pc         (next_pc),
      .next_misaligned (next_misaligned)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= FETCH;
      else
         state <= state_n;
   end

   // Leaving EXEC always retires the instruction, whether it goes back to FETCH or stops.
   always_comb begin
      state_n = state;
      pc_load = 1'b0;
      retire  = 1'b0;
      set_err = 1'b0;
      case (state)
         FETCH: begin
            if (imem_ready)
               state_n = EXEC;
         end
         EXEC: begin
            if (stall) begin
               state_n = EXEC;
            end else if (halt) begin
               state_n = HALTED;
               retire  = 1'b1;
            end else if (next_misaligned) begin
               state_n = HALTED;
               retire  = 1'b1;
               set_err = 1'b1;
            end else begin
               state_n = FETCH;
               retire  = 1'b1;
               pc_load = 1'b1;
            end
         end
         HALTED: state_n = HALTED;
         default: state_n = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         retired_cnt  <= 32'd0;
         misalign_err <= 1'b0;
      end else begin
         if (pc_load)
            pc <= next_pc;
         if (retire)
            retired_cnt <= retired_cnt + 32'd1;
         if (set_err)
            misalign_err <= 1'b1;
      end
   end

   assign imem_req    = (state == FETCH);
   assign instr_valid = (state == EXEC);
   assign halted      = (state == HALTED);
   assign retired     = retired_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed instructions, expected post-retire state queued by stimulus,
// checked by a monitor each time the DUT leaves EXEC; plus direct reset/ignore/timing checks.
// Ports: none (top-level bench).
module tb_pc_sequencer;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] ret;
      logic        halted;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_plus4;
   logic [31:0] branch_target;
   logic        branch_taken;
   logic        jump;
   logic [25:0] jump_index;
   logic        jr;
   logic [31:0] jr_addr;
   logic        stall;
   logic        halt;
   logic        imem_ready;
   logic [31:0] pc;
   logic        imem_req;
   logic        instr_valid;
   logic        halted;
   logic        misalign_err;
   logic [31:0] retired;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   logic prev_iv = 1'b0;

   pc_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_plus4      (pc_plus4),
      .branch_target (branch_target),
      .branch_taken  (branch_taken),
      .jump          (jump),
      .jump_index    (jump_index),
      .jr            (jr),
      .jr_addr       (jr_addr),
      .stall         (stall),
      .halt          (halt),
      .imem_ready    (imem_ready),
      .pc            (pc),
      .imem_req      (imem_req),
      .instr_valid   (instr_valid),
      .halted        (halted),
      .misalign_err  (misalign_err),
      .retired       (retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: the DUT presents a result each time it leaves EXEC.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && prev_iv === 1'b1 && instr_valid === 1'b0) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_retire: pc %h retired %h, no entry queued", pc, retired);
            end else begin
               e = q.pop_front();
               chk({e.name, ".pc"},      pc,                   e.pc);
               chk({e.name, ".retired"}, retired,              e.ret);
               chk({e.name, ".halted"},  {31'd0, halted},      {31'd0, e.halted});
               chk({e.name, ".err"},     {31'd0, misalign_err}, {31'd0, e.err});
            end
         end
         prev_iv = instr_valid;
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, checks %0d", checks);
      $fatal(1, "timeout");
   end

   task automatic clear_ctl();
      branch_taken = 1'b0;
      jump         = 1'b0;
      jr           = 1'b0;
      stall        = 1'b0;
      halt         = 1'b0;
   endtask

   // One instruction starting from a negedge in FETCH. Counts EXEC cycles and watches pc.
   task automatic run_instr(input string nm, input int waits, input int stalls, input bit hs,
                            input logic [31:0] p4, input logic br, input logic [31:0] bt,
                            input logic j, input logic [25:0] ji, input logic jrr,
                            input logic [31:0] ja, input logic h,
                            input logic [31:0] epc, input logic [31:0] eret,
                            input logic ehalt, input logic eerr);
      int          cnt = 0;
      logic        stable = 1'b1;
      logic [31:0] p0 = pc;
      exp_t        e;
      pc_plus4   = p4;
      imem_ready = 1'b0;
      for (int i = 0; i < waits; i++) begin
         if (instr_valid) cnt++;
         if (pc !== p0) stable = 1'b0;
         @(negedge clk);
      end
      imem_ready = 1'b1;
      if (instr_valid) cnt++;
      if (pc !== p0) stable = 1'b0;
      @(negedge clk);
      imem_ready = 1'b0;
      stall      = 1'b1;
      halt       = hs;
      for (int i = 0; i < stalls; i++) begin
         if (instr_valid) cnt++;
         if (pc !== p0) stable = 1'b0;
         @(negedge clk);
      end
      stall         = 1'b0;
      halt          = h;
      branch_taken  = br;
      branch_target = bt;
      jump          = j;
      jump_index    = ji;
      jr            = jrr;
      jr_addr       = ja;
      e.name = nm; e.pc = epc; e.ret = eret; e.halted = ehalt; e.err = eerr;
      q.push_back(e);
      if (instr_valid) cnt++;
      if (pc !== p0) stable = 1'b0;
      @(negedge clk);
      clear_ctl();
      chk({nm, ".exec_cycles"}, cnt, stalls + 1);
      chk({nm, ".pc_held"}, {31'd0, stable}, 32'd1);
   endtask

   task automatic chk_reset_state(input string nm);
      chk({nm, ".pc"},          pc,                    32'h0);
      chk({nm, ".imem_req"},    {31'd0, imem_req},     32'd1);
      chk({nm, ".instr_valid"}, {31'd0, instr_valid},  32'd0);
      chk({nm, ".halted"},      {31'd0, halted},       32'd0);
      chk({nm, ".err"},         {31'd0, misalign_err}, 32'd0);
      chk({nm, ".retired"},     retired,               32'd0);
   endtask

   task automatic poke_ignored(input string nm, input logic [31:0] epc, input logic [31:0] eret);
      for (int i = 0; i < 3; i++) begin
         imem_ready   = 1'b1;
         jr           = 1'b1;
         jr_addr      = 32'h0000_0040;
         branch_taken = 1'b1;
         @(negedge clk);
         imem_ready = 1'b0;
         @(negedge clk);
      end
      clear_ctl();
      chk({nm, ".pc"},       pc,                {31'd0, 1'b0} | epc);
      chk({nm, ".halted"},   {31'd0, halted},   32'd1);
      chk({nm, ".imem_req"}, {31'd0, imem_req}, 32'd0);
      chk({nm, ".retired"},  retired,           eret);
   endtask

   initial begin
      rst_n         = 1'b0;
      pc_plus4      = 32'h0;
      branch_target = 32'h0;
      jump_index    = 26'h0;
      jr_addr       = 32'h0;
      imem_ready    = 1'b0;
      clear_ctl();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_state("reset");

      //        name         wt st hs  pc_plus4      br  br_target     j   index       jr  jr_addr       h    exp_pc        ret           hlt  err
      run_instr("seq",        0, 0, 0, 32'h0000_0004, 0, 32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h0000_0004, 32'd1,        0, 0);
      run_instr("wait_stall", 3, 2, 1, 32'h0000_0008, 0, 32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h0000_0008, 32'd2,        0, 0);
      run_instr("jr_setup",   0, 0, 0, 32'h0000_000C, 0, 32'h0,        0, 26'h0,       1, 32'h0040_0010, 0, 32'h0040_0010, 32'd3,       0, 0);
      run_instr("prio_all",   1, 0, 0, 32'h0040_0014, 1, 32'h0040_0200, 1, 26'h000_0020, 1, 32'h0040_0100, 0, 32'h0040_0100, 32'd4,      0, 0);
      run_instr("prio_jump",  0, 1, 0, 32'h0040_0104, 0, 32'h0,        1, 26'h000_0020, 0, 32'h0,       0, 32'h0000_0080, 32'd5,        0, 0);
      run_instr("jump_nib",   0, 0, 0, 32'h1000_0084, 1, 32'h0,        1, 26'h3FF_FFFF, 0, 32'h0,       0, 32'h1FFF_FFFC, 32'd6,        0, 0);
      run_instr("br_taken",   2, 0, 0, 32'h2000_0000, 1, 32'h0000_0200, 0, 26'h0,      0, 32'h0000_0003, 0, 32'h0000_0200, 32'd7,       0, 0);
      run_instr("jr_wrap",    0, 0, 0, 32'h0000_0204, 0, 32'h0,        0, 26'h0,       1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'd8,       0, 0);
      run_instr("seq_wrap",   0, 0, 0, 32'h0000_0000, 0, 32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h0000_0000, 32'd9,        0, 0);

      // In FETCH here, so no retire edge can overwrite the deposited count.
      dut.retired_cnt = 32'hFFFF_FFFF;
      run_instr("ret_wrap",   0, 0, 0, 32'h0000_0004, 0, 32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h0000_0004, 32'd0,        0, 0);
      run_instr("misalign",   0, 0, 0, 32'h0000_0008, 1, 32'h0000_0102, 0, 26'h0,      0, 32'h0,        0, 32'h0000_0004, 32'd1,        1, 1);
      poke_ignored("misalign_hold", 32'h0000_0004, 32'd1);
      chk("misalign_hold.err", {31'd0, misalign_err}, 32'd1);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_state("reset_after_err");

      run_instr("halt_br",    0, 0, 0, 32'h0000_0004, 1, 32'h0000_0100, 0, 26'h0,      0, 32'h0,        1, 32'h0000_0000, 32'd1,        1, 0);
      poke_ignored("halt_hold", 32'h0000_0000, 32'd1);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_state("reset_after_halt");

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
